// File: rtl/intersection_scheduler.sv
// Ray/triangle intersection job scheduler.
// Accepts one ray job, streams the job's triangles from memory into a pipelined
// intersection unit at one per cycle, tracks the closest hit as in-order results
// return, and presents the closest hit until the consumer takes it.
module intersection_scheduler #(
    parameter int                 IDX_W = 16,
    parameter logic signed [31:0] MAX_T = 32'sh7FFFFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic signed [31:0]      i_ray [0:1][0:2],
    input  logic [IDX_W-1:0]        i_tri_base,
    input  logic [IDX_W-1:0]        i_tri_count,
    output logic [IDX_W-1:0]        o_tri_addr,
    output logic                    o_tri_rd,
    input  logic signed [31:0]      i_tri_data [0:2][0:2],
    output logic                    o_int_en,
    output logic signed [31:0]      o_int_tri [0:2][0:2],
    output logic signed [31:0]      o_int_ray [0:1][0:2],
    input  logic                    i_int_valid,
    input  logic                    i_int_result,
    input  logic signed [31:0]      i_int_t,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic                    o_hit,
    output logic [IDX_W-1:0]        o_hit_idx,
    output logic signed [31:0]      o_hit_t
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       base_reg;
    logic [IDX_W-1:0]       count_reg;
    logic [IDX_W-1:0]       issue_cnt_reg;
    logic [IDX_W-1:0]       ret_cnt_reg;
    logic [IDX_W-1:0]       ret_cnt_next;
    logic                   best_hit_reg;
    logic [IDX_W-1:0]       best_idx_reg;
    logic signed [31:0]     best_t_reg;
    logic                   int_en_reg;
    logic signed [31:0]     ray_reg [0:1][0:2];
    logic                   accept;
    logic                   ret_fire;

    // A job is taken only while idle; results count only while the job is in flight.
    assign accept       = (state_reg == IDLE) && i_req_valid;
    assign ret_fire     = i_int_valid && ((state_reg == ISSUE) || (state_reg == DRAIN));
    assign ret_cnt_next = ret_fire ? ret_cnt_reg + IDX_W'(1) : ret_cnt_reg;

    // Next-state and per-state strobes.
    always_comb begin
        state_next  = state_reg;
        o_req_ready = 1'b0;
        o_tri_rd    = 1'b0;
        o_res_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    state_next = (i_tri_count == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                o_tri_rd = 1'b1;
                if (issue_cnt_reg == count_reg - IDX_W'(1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                // Counts the return arriving this very cycle.
                if (ret_cnt_next == count_reg)
                    state_next = DONE;
            end
            DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters, job latches and closest-hit tracking.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            count_reg     <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            best_hit_reg  <= 1'b0;
            best_idx_reg  <= '0;
            best_t_reg    <= MAX_T;
            int_en_reg    <= 1'b0;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 3; c++)
                    ray_reg[r][c] <= '0;
        end else begin
            state_reg  <= state_next;
            // Memory data lands one cycle after the read, so the issue strobe trails it.
            int_en_reg <= o_tri_rd;
            if (accept) begin
                base_reg      <= i_tri_base;
                count_reg     <= i_tri_count;
                issue_cnt_reg <= '0;
                ret_cnt_reg   <= '0;
                best_hit_reg  <= 1'b0;
                best_idx_reg  <= '0;
                best_t_reg    <= MAX_T;
                ray_reg       <= i_ray;
            end else begin
                if (o_tri_rd)
                    issue_cnt_reg <= issue_cnt_reg + IDX_W'(1);
                if (ret_fire) begin
                    ret_cnt_reg <= ret_cnt_next;
                    // Strict compare: an equal t later in the list never displaces an earlier one.
                    if (i_int_result && (i_int_t < best_t_reg)) begin
                        best_hit_reg <= 1'b1;
                        best_idx_reg <= ret_cnt_reg;
                        best_t_reg   <= i_int_t;
                    end
                end
            end
        end
    end

    // Operands are forced to zero whenever no issue is taking place.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_vert
            for (genvar gj = 0; gj < 3; gj++) begin : g_comp
                assign o_int_tri[gi][gj] = int_en_reg ? i_tri_data[gi][gj] : 32'sd0;
            end
        end
    endgenerate

    assign o_tri_addr = base_reg + issue_cnt_reg;
    assign o_int_en   = int_en_reg;
    assign o_int_ray  = ray_reg;
    assign o_hit      = best_hit_reg;
    assign o_hit_idx  = best_idx_reg;
    assign o_hit_t    = best_t_reg;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed and random jobs, a behavioural
// triangle memory and intersection unit, and a closest-hit reference model.
module tb_intersection_scheduler;

    localparam logic signed [31:0] MAX_T = 32'sh7FFFFFFF;

    logic               i_clk = 1'b0;
    logic               i_rstn;
    logic               i_req_valid;
    logic               o_req_ready;
    logic signed [31:0] i_ray [0:1][0:2];
    logic [15:0]        i_tri_base;
    logic [15:0]        i_tri_count;
    logic [15:0]        o_tri_addr;
    logic               o_tri_rd;
    logic signed [31:0] i_tri_data [0:2][0:2];
    logic               o_int_en;
    logic signed [31:0] o_int_tri [0:2][0:2];
    logic signed [31:0] o_int_ray [0:1][0:2];
    logic               i_int_valid;
    logic               i_int_result;
    logic signed [31:0] i_int_t;
    logic               o_res_valid;
    logic               i_res_ready;
    logic               o_hit;
    logic [15:0]        o_hit_idx;
    logic signed [31:0] o_hit_t;

    intersection_scheduler dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_ray        (i_ray),
        .i_tri_base   (i_tri_base),
        .i_tri_count  (i_tri_count),
        .o_tri_addr   (o_tri_addr),
        .o_tri_rd     (o_tri_rd),
        .i_tri_data   (i_tri_data),
        .o_int_en     (o_int_en),
        .o_int_tri    (o_int_tri),
        .o_int_ray    (o_int_ray),
        .i_int_valid  (i_int_valid),
        .i_int_result (i_int_result),
        .i_int_t      (i_int_t),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_hit        (o_hit),
        .o_hit_idx    (o_hit_idx),
        .o_hit_t      (o_hit_t)
    );

    always #5 i_clk = ~i_clk;

    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;
    bit                 in_job = 0;
    bit                 spur = 0;
    int                 lat = 1;
    int                 jn = 0;
    logic [15:0]        jb = '0;
    bit                 jhit [64];
    logic signed [31:0] jt [64];
    logic signed [31:0] job_ray [0:1][0:2];
    int                 rd_cnt = 0;
    int                 en_cnt = 0;
    bit                 rd_prev = 0;
    logic [15:0]        addr_prev = '0;
    int                 due_q [$];
    int                 k_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Triangle memory contents: each word encodes its address, vertex and component.
    function automatic logic signed [31:0] memv(input logic [15:0] a, input int v, input int c);
        return $signed({a, 4'(v), 4'(c), 8'h5A});
    endfunction

    // Closest hit: smallest t among hits below MAX_T, earliest index among equals.
    task automatic expect_best(output bit eh, output logic [15:0] ei, output logic signed [31:0] et);
        et = MAX_T;
        eh = 0;
        ei = '0;
        for (int k = 0; k < jn; k++)
            if (jhit[k] && jt[k] < et) et = jt[k];
        if (et != MAX_T) begin
            eh = 1;
            for (int k = jn - 1; k >= 0; k--)
                if (jhit[k] && jt[k] == et) ei = 16'(k);
        end
    endtask

    // One clock: drive memory/intersection responses, then sample and check outputs.
    task automatic tick();
        int k;
        @(posedge i_clk);
        #1;
        cyc++;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                i_tri_data[v][c] = rd_prev ? memv(addr_prev, v, c) : $signed($urandom());
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            k = k_q.pop_front();
            i_int_valid  = 1'b1;
            i_int_result = jhit[k % 64];
            i_int_t      = jt[k % 64];
        end else if (spur) begin
            i_int_valid  = 1'b1;
            i_int_result = 1'b1;
            i_int_t      = 32'sh80000000;
        end else begin
            i_int_valid  = 1'b0;
            i_int_result = 1'($urandom());
            i_int_t      = $signed($urandom());
        end
        #1;
        if (in_job) begin
            check("req_ready_busy", o_req_ready, 0);
            if (o_tri_rd) begin
                check("tri_addr", o_tri_addr, 16'(jb + 16'(rd_cnt)));
                rd_cnt++;
            end
            if (o_int_en) begin
                for (int v = 0; v < 3; v++)
                    for (int c = 0; c < 3; c++)
                        check("int_tri", o_int_tri[v][c], memv(16'(jb + 16'(en_cnt)), v, c));
                due_q.push_back(cyc + lat);
                k_q.push_back(en_cnt);
                en_cnt++;
            end
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 3; c++)
                    check("int_ray", o_int_ray[r][c], job_ray[r][c]);
        end
        rd_prev   = o_tri_rd;
        addr_prev = o_tri_addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tri_rd"}, o_tri_rd, 0);
        check({tag, "_int_en"}, o_int_en, 0);
        check({tag, "_res_valid"}, o_res_valid, 0);
        check({tag, "_hit"}, o_hit, 0);
        check({tag, "_hit_idx"}, o_hit_idx, 0);
        check({tag, "_hit_t"}, o_hit_t, MAX_T);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                check({tag, "_ray"}, o_int_ray[r][c], 0);
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                check({tag, "_tri"}, o_int_tri[v][c], 0);
    endtask

    task automatic run_job(input logic [15:0] base, input int n, input int l, input int hold, input int abort_at);
        int                 waited;
        bit                 got;
        bit                 eh;
        logic [15:0]        ei;
        logic signed [31:0] et;
        check("req_ready_idle", o_req_ready, 1);
        jb = base;
        jn = n;
        lat = l;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin
                job_ray[r][c] = $signed($urandom());
                i_ray[r][c]   = job_ray[r][c];
            end
        i_tri_base  = base;
        i_tri_count = 16'(n);
        i_req_valid = 1'b1;
        rd_cnt = 0;
        en_cnt = 0;
        due_q.delete();
        k_q.delete();
        spur   = 0;
        in_job = 1;
        tick();
        i_req_valid = 1'b0;
        i_tri_base  = 16'($urandom());
        i_tri_count = 16'($urandom());
        waited = 1;
        got = o_res_valid;
        while (!got && waited < n + l + 12) begin
            if (waited == abort_at) begin
                i_rstn = 1'b0;
                #1;
                check_reset_outputs("abort");
                in_job = 0;
                due_q.delete();
                k_q.delete();
                repeat (2) @(posedge i_clk);
                #2;
                i_rstn  = 1'b1;
                rd_prev = 0;
                tick();
                check("ready_after_abort", o_req_ready, 1);
                check("no_result_after_abort", o_res_valid, 0);
                tick();
                check("no_result_after_abort2", o_res_valid, 0);
                return;
            end
            tick();
            waited++;
            got = o_res_valid;
        end
        in_job = 0;
        check("res_valid_seen", got, 1);
        if (n == 0) check("zero_count_latency", waited, 1);
        check("rd_pulses", rd_cnt, n);
        check("int_en_pulses", en_cnt, n);
        expect_best(eh, ei, et);
        check("hit", o_hit, eh);
        check("hit_idx", o_hit_idx, ei);
        check("hit_t", o_hit_t, et);
        $display("job base=%04h n=%0d lat=%0d -> hit=%0d idx=%0d t=%08h", base, n, l, o_hit, o_hit_idx, o_hit_t);
        // Consumer stalls while junk requests and stray results arrive.
        spur        = 1;
        i_req_valid = 1'b1;
        i_tri_count = 16'd5;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_res_valid", o_res_valid, 1);
            check("hold_req_ready", o_req_ready, 0);
            check("hold_hit", o_hit, eh);
            check("hold_idx", o_hit_idx, ei);
            check("hold_t", o_hit_t, et);
        end
        i_res_ready = 1'b1;
        tick();
        i_req_valid = 1'b0;
        i_res_ready = 1'b0;
        check("handoff_ready", o_req_ready, 1);
        check("handoff_res_valid", o_res_valid, 0);
        tick();
        check("no_accept_in_handoff", o_req_ready, 1);
        spur = 0;
    endtask

    initial begin
        logic [15:0] b;
        int          n;
        i_rstn       = 1'b0;
        i_req_valid  = 1'b0;
        i_tri_base   = '0;
        i_tri_count  = '0;
        i_int_valid  = 1'b0;
        i_int_result = 1'b0;
        i_int_t      = '0;
        i_res_ready  = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                i_ray[r][c] = '0;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                i_tri_data[v][c] = '0;
        #12;
        check_reset_outputs("reset");
        #10;
        i_rstn = 1'b1;
        tick();
        check("ready_after_reset", o_req_ready, 1);

        // Closest of three hits in the middle of the list.
        jhit[0] = 0; jt[0] = 32'sh00005000;
        jhit[1] = 1; jt[1] = 32'sh00030000;
        jhit[2] = 1; jt[2] = 32'sh00010000;
        jhit[3] = 1; jt[3] = 32'sh00020000;
        run_job(16'h0100, 4, 2, 1, -1);
        check("d1_idx", o_hit_idx, 2);

        // All misses.
        for (int k = 0; k < 3; k++) begin jhit[k] = 0; jt[k] = 32'sh100; end
        run_job(16'h0200, 3, 3, 0, -1);

        // Empty job.
        run_job(16'h0300, 0, 1, 2, -1);

        // Tie keeps the earlier index; addresses wrap past 0xFFFF; long consumer stall.
        jhit[0] = 1; jt[0] = 32'sh00008000;
        jhit[1] = 0; jt[1] = 32'sh00001000;
        jhit[2] = 1; jt[2] = 32'sh00008000;
        run_job(16'hFFFE, 3, 1, 10, -1);

        // Reset while draining, then a single-triangle job.
        for (int k = 0; k < 8; k++) begin jhit[k] = 1; jt[k] = 32'sh1000 * (k + 1); end
        run_job(16'h0400, 8, 3, 0, 10);
        jhit[0] = 1; jt[0] = 32'sh00005000;
        run_job(16'h0500, 1, 2, 0, -1);
        check("d5_t", o_hit_t, 32'sh00005000);

        // Random jobs with frequent ties, negative t and MAX_T hits.
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(0, 12);
            b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom());
            for (int k = 0; k < n; k++) begin
                jhit[k] = 1'($urandom_range(0, 1));
                jt[k]   = $signed(32'($urandom_range(1, 5)) << 14);
                if ($urandom_range(0, 2) == 0) jt[k] = -jt[k];
                if ($urandom_range(0, 9) == 0) jt[k] = MAX_T;
            end
            run_job(b, n, $urandom_range(1, 4), $urandom_range(0, 3), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
